captura_matricula: RTL and testbench

//  Front end of the parking-barrier datapath. Receives a licence plate one
//  4-bit digit at a time over a valid/ready handshake, plus a 3-bit door code.

---
 rtl/captura_matricula.sv | 269 ++++++++++++++++++++++++++
 tb/tb_captura_matricula.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_matricula.sv
// -----------------------------------------------------------------------------
// captura_matricula
//
// Front end of the parking-barrier datapath. A licence plate arrives one 4-bit
// digit at a time over a valid/ready handshake. A 3-bit door code arrives with
// the sixth digit. The assembled plate is presented on m5..m0 / d to the
// plate-checking logic for a fixed hold window. The checker's Valido verdict
// is sampled on the last hold cycle, and saturating accepted/rejected vehicle
// counts are kept.
//
// Handshake: a digit transfers on a rising clk edge when digit_valid and
// digit_ready are both high. digit_ready is combinational:
// (IDLE or COLLECT) and not cancel. The sender may hold digit_valid high for
// any number of cycles and may change digit_in only after a transfer.
//
// Parameters
//   TIMEOUT_CYCLES  max idle cycles between digits while collecting
//   HOLD_CYCLES     cycles plate_valid stays high per presented plate (>=1)
//   CNT_W           width of accepted_cnt / rejected_cnt
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   digit_in       in   plate digit; the first digit of a plate lands in m5
//   digit_valid    in   digit_in is valid this cycle
//   digit_ready    out  block accepts a digit this cycle
//   door_in        in   door code, sampled on the 6th digit transfer
//   cancel         in   discard the plate currently being collected
//   valido_in      in   checker verdict, sampled on the last hold cycle
//   m5..m0         out  presented plate digits (m5 = first received)
//   d              out  presented door code
//   plate_valid    out  m5..m0/d form a plate to be checked now
//   abort          out  1-cycle pulse: plate discarded
//   accepted_cnt   out  plates with valido_in=1, saturating
//   rejected_cnt   out  plates with valido_in=0, saturating
//   state_dbg      out  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module captura_matricula #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int HOLD_CYCLES    = 4,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic [2:0]       door_in,
    input  logic             cancel,
    input  logic             valido_in,
    output logic [3:0]       m5,
    output logic [3:0]       m4,
    output logic [3:0]       m3,
    output logic [3:0]       m2,
    output logic [3:0]       m1,
    output logic [3:0]       m0,
    output logic [2:0]       d,
    output logic             plate_valid,
    output logic             abort,
    output logic [CNT_W-1:0] accepted_cnt,
    output logic [CNT_W-1:0] rejected_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_INIT  = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [HW-1:0]    hold_q, hold_d;

    // Shadow slots for the first five digits. Slot 0 is never stored: the
    // sixth digit goes straight from digit_in into m0 on commit.
    logic [3:0]       shadow_q [1:5];
    logic [3:0]       shadow_d [1:5];

    logic [3:0]       m5_q, m5_d, m4_q, m4_d, m3_q, m3_d;
    logic [3:0]       m2_q, m2_d, m1_q, m1_d, m0_q, m0_d;
    logic [2:0]       d_q, d_d;
    logic             pv_q, pv_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    logic             xfer;

    assign digit_ready = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && !cancel;
    assign xfer        = digit_valid && digit_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        hold_d   = hold_q;
        shadow_d = shadow_q;
        m5_d     = m5_q;
        m4_d     = m4_q;
        m3_d     = m3_q;
        m2_d     = m2_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        d_d      = d_q;
        pv_d     = pv_q;
        abort_d  = 1'b0;
        acc_d    = acc_q;
        rej_d    = rej_q;

        case (state_q)
            S_IDLE: begin
                // cancel here only masks digit_ready; there is nothing to discard.
                if (xfer) begin
                    shadow_d[5] = digit_in;
                    idx_d       = 3'd4;
                    timer_d     = '0;
                    state_d     = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    // cancel wins over both a same-cycle digit (ready is low)
                    // and a same-cycle timeout.
                    abort_d = 1'b1;
                    idx_d   = 3'd5;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    timer_d = '0;
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd5;
                        if (door_in == 3'b000) begin
                            // Door 000 is not a real door: drop the plate.
                            abort_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            m5_d    = shadow_q[5];
                            m4_d    = shadow_q[4];
                            m3_d    = shadow_q[3];
                            m2_d    = shadow_q[2];
                            m1_d    = shadow_q[1];
                            m0_d    = digit_in;
                            d_d     = door_in;
                            pv_d    = 1'b1;
                            hold_d  = HOLD_INIT;
                            state_d = S_PRESENT;
                        end
                    end else begin
                        for (int i = 1; i <= 5; i++) begin
                            if (idx_q == 3'(i)) begin
                                shadow_d[i] = digit_in;
                            end
                        end
                        idx_d = idx_q - 3'd1;
                    end
                end else begin
                    if (timer_q == TIMER_LAST) begin
                        abort_d = 1'b1;
                        idx_d   = 3'd5;
                        timer_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            S_PRESENT: begin
                // Last hold cycle: take the checker's verdict and release.
                if (hold_q == '0) begin
                    if (valido_in) begin
                        if (acc_q != CNT_MAX) begin
                            acc_d = acc_q + CNT_W'(1);
                        end
                    end else begin
                        if (rej_q != CNT_MAX) begin
                            rej_d = rej_q + CNT_W'(1);
                        end
                    end
                    pv_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd5;
                timer_d = '0;
                pv_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd5;
            timer_q <= '0;
            hold_q  <= '0;
            for (int i = 1; i <= 5; i++) begin
                shadow_q[i] <= '0;
            end
            m5_q    <= '0;
            m4_q    <= '0;
            m3_q    <= '0;
            m2_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            d_q     <= '0;
            pv_q    <= 1'b0;
            abort_q <= 1'b0;
            acc_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            hold_q   <= hold_d;
            shadow_q <= shadow_d;
            m5_q     <= m5_d;
            m4_q     <= m4_d;
            m3_q     <= m3_d;
            m2_q     <= m2_d;
            m1_q     <= m1_d;
            m0_q     <= m0_d;
            d_q      <= d_d;
            pv_q     <= pv_d;
            abort_q  <= abort_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m5           = m5_q;
    assign m4           = m4_q;
    assign m3           = m3_q;
    assign m2           = m2_q;
    assign m1           = m1_q;
    assign m0           = m0_q;
    assign d            = d_q;
    assign plate_valid  = pv_q;
    assign abort        = abort_q;
    assign accepted_cnt = acc_q;
    assign rejected_cnt = rej_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_captura_matricula.sv
// Directed testbench for captura_matricula. Inputs change 1 ns after a rising
// edge; outputs are sampled at that point as well.
module tb_captura_matricula;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic [2:0] door_in;
    logic       cancel;
    logic       valido_in;
    logic [3:0] m5, m4, m3, m2, m1, m0;
    logic [2:0] d;
    logic       plate_valid;
    logic       abort;
    logic [3:0] accepted_cnt;
    logic [3:0] rejected_cnt;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_bad    = 0;

    captura_matricula #(
        .TIMEOUT_CYCLES(16),
        .HOLD_CYCLES   (4),
        .CNT_W         (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .door_in      (door_in),
        .cancel       (cancel),
        .valido_in    (valido_in),
        .m5           (m5),
        .m4           (m4),
        .m3           (m3),
        .m2           (m2),
        .m1           (m1),
        .m0           (m0),
        .d            (d),
        .plate_valid  (plate_valid),
        .abort        (abort),
        .accepted_cnt (accepted_cnt),
        .rejected_cnt (rejected_cnt),
        .state_dbg    (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] plate_out();
        return {m5, m4, m3, m2, m1, m0};
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Six back-to-back digits; first digit is plate[23:20]. Returns one cycle
    // after the sixth transfer.
    task automatic send_plate(input logic [23:0] plate, input logic [2:0] door);
        for (int i = 0; i < 6; i++) begin
            digit_valid = 1'b1;
            digit_in    = plate[23-4*i -: 4];
            door_in     = door;
            #1;
            check("ready_digit", 32'(digit_ready), 32'd1);
            step();
        end
        digit_valid = 1'b0;
        door_in     = 3'b000;
    endtask

    // Walk the 4 hold cycles; the verdict is only correct on the last one.
    task automatic finish_hold(input logic v);
        for (int k = 0; k < 4; k++) begin
            valido_in = (k == 3) ? v : ~v;
            check("hold_pv", 32'(plate_valid), 32'd1);
            check("hold_ready", 32'(digit_ready), 32'd0);
            check("hold_abort", 32'(abort), 32'd0);
            step();
        end
        valido_in = 1'b0;
        check("hold_release_pv", 32'(plate_valid), 32'd0);
    endtask

    // Stimulus
    initial begin
        int abort_cnt;
        int abort_at;

        reset       = 1'b1;
        digit_in    = '0;
        digit_valid = 1'b0;
        door_in     = '0;
        cancel      = 1'b0;
        valido_in   = 1'b0;
        do_reset();

        // Reset state
        check("rst_plate", 32'(plate_out()), 32'h0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_pv", 32'(plate_valid), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_acc", 32'(accepted_cnt), 32'd0);
        check("rst_rej", 32'(rejected_cnt), 32'd0);
        check("rst_ready", 32'(digit_ready), 32'd1);

        // Tests 1+2: 3,4,A,3,6,6 door 001, accepted
        send_plate(24'h34A366, 3'b001);
        check("t1_plate", 32'(plate_out()), 32'h34A366);
        check("t1_d", 32'(d), 32'd1);
        finish_hold(1'b1);
        check("t2_acc", 32'(accepted_cnt), 32'd1);
        check("t2_rej", 32'(rejected_cnt), 32'd0);

        send_plate(24'h012345, 3'b101);
        check("t2b_plate", 32'(plate_out()), 32'h012345);
        check("t2b_d", 32'(d), 32'd5);
        finish_hold(1'b0);
        check("t2b_acc", 32'(accepted_cnt), 32'd1);
        check("t2b_rej", 32'(rejected_cnt), 32'd1);

        // cancel in IDLE: no abort
        cancel = 1'b1;
        #1;
        check("idle_cancel_ready", 32'(digit_ready), 32'd0);
        step();
        cancel = 1'b0;
        check("idle_cancel_abort", 32'(abort), 32'd0);

        // Test 3: three digits then 16 idle cycles -> abort
        for (int i = 1; i <= 3; i++) begin
            digit_valid = 1'b1;
            digit_in    = 4'(i);
            step();
        end
        digit_valid = 1'b0;
        abort_cnt = 0;
        abort_at  = 0;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (abort) begin
                abort_cnt++;
                if (abort_at == 0) abort_at = s;
            end
        end
        check("t3_abort_pulses", 32'(abort_cnt), 32'd1);
        check("t3_abort_cycle", 32'(abort_at), 32'd16);
        check("t3_plate_kept", 32'(plate_out()), 32'h012345);
        check("t3_d_kept", 32'(d), 32'd5);
        send_plate(24'hBD9752, 3'b111);
        check("t3_plate", 32'(plate_out()), 32'hBD9752);
        check("t3_d", 32'(d), 32'd7);
        finish_hold(1'b0);
        check("t3_rej", 32'(rejected_cnt), 32'd2);

        // Test 4: door 000 on 6th digit
        send_plate(24'h111111, 3'b000);
        check("t4_pv", 32'(plate_valid), 32'd0);
        check("t4_abort", 32'(abort), 32'd1);
        check("t4_plate_kept", 32'(plate_out()), 32'hBD9752);
        check("t4_d_kept", 32'(d), 32'd7);
        step();
        check("t4_abort_end", 32'(abort), 32'd0);
        check("t4_pv_end", 32'(plate_valid), 32'd0);
        check("t4_acc", 32'(accepted_cnt), 32'd1);
        check("t4_rej", 32'(rejected_cnt), 32'd2);

        // Test 5: cancel with digit_valid after two digits
        digit_valid = 1'b1;
        digit_in    = 4'hA;
        step();
        digit_in    = 4'hB;
        step();
        digit_in    = 4'hC;
        cancel      = 1'b1;
        #1;
        check("t5_ready_low", 32'(digit_ready), 32'd0);
        step();
        cancel      = 1'b0;
        digit_valid = 1'b0;
        check("t5_abort", 32'(abort), 32'd1);
        step();
        check("t5_abort_end", 32'(abort), 32'd0);
        send_plate(24'hC0FFEE, 3'b010);
        check("t5_plate", 32'(plate_out()), 32'hC0FFEE);
        check("t5_d", 32'(d), 32'd2);
        finish_hold(1'b1);
        check("t5_acc", 32'(accepted_cnt), 32'd2);

        // Test 6: saturation from a fresh start
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            send_plate(24'h100000 + 24'(p), 3'b011);
            finish_hold(1'b1);
            if (p == 14) check("t6_acc_14", 32'(accepted_cnt), 32'd14);
            if (p == 15) check("t6_acc_15", 32'(accepted_cnt), 32'd15);
        end
        check("t6_acc_sat", 32'(accepted_cnt), 32'd15);
        check("t6_rej", 32'(rejected_cnt), 32'd0);

        // Reset during PRESENT
        send_plate(24'h987654, 3'b110);
        check("t6_pv_before", 32'(plate_valid), 32'd1);
        step();
        reset     = 1'b1;
        valido_in = 1'b1;
        step();
        reset     = 1'b0;
        valido_in = 1'b0;
        check("t6_rst_plate", 32'(plate_out()), 32'h0);
        check("t6_rst_d", 32'(d), 32'd0);
        check("t6_rst_pv", 32'(plate_valid), 32'd0);
        check("t6_rst_abort", 32'(abort), 32'd0);
        check("t6_rst_acc", 32'(accepted_cnt), 32'd0);
        check("t6_rst_rej", 32'(rejected_cnt), 32'd0);
        check("t6_rst_ready", 32'(digit_ready), 32'd1);

        // Report
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
